sraml_bus_arbiter: RTL and testbench

Two-into-one arbiter for the CPU's SRAM-like memory ports. It sits between the instruction and data SRAM→SRAM-like bridges and a single SRAM-like master port feeding the AXI interface, sharing that one port between fetch and load/store. It grants one requester at a time, latches that request, and steers `addr_ok`/`data_ok`/`rdata` back to the owner. Only one transaction is in flight at any time.

---
 rtl/sraml_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_sraml_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sraml_bus_arbiter.sv
// sraml_bus_arbiter
//   Shares one SRAM-like master port between the instruction-fetch and the
//   load/store SRAM-like bridges. One transaction is in flight at a time: the
//   winner's request is latched, driven on the shared port, and the slave's
//   addr_ok / data_ok / rdata are steered back to the owner.
//
//   Optional feature macro: SRAML_ARB_RR_EN
//     defined   : round-robin on a tie (grant the side opposite the last grant)
//     undefined : fixed priority, data side wins a tie
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   inst_req/wr/size/addr/wdata    instruction-side request
//   inst_addr_ok/data_ok/rdata     instruction-side responses
//   data_req/wr/size/addr/wdata    data-side request
//   data_addr_ok/data_ok/rdata     data-side responses
//   req/wr/size/addr/wdata         shared master request (registered)
//   addr_ok/data_ok/rdata          slave handshakes and read data
module sraml_bus_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [DW-1:0] inst_addr,
  input  logic [DW-1:0] inst_wdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [DW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          req,
  output logic          wr,
  output logic [1:0]    size,
  output logic [DW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic          addr_ok,
  input  logic          data_ok,
  input  logic [DW-1:0] rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t        r_state;
  logic          r_owner;   // 0 = inst, 1 = data
  logic          r_req;
  logic          r_wr;
  logic [1:0]    r_size;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic w_aok;
  logic w_dok;
  logic w_arb;
  logic w_any;
  logic w_pick_data;

  // Slave handshakes only count in the phase that expects them; a data_ok
  // arriving together with addr_ok in ADDR completes the transaction at once.
  assign w_aok = (r_state == S_ADDR) & addr_ok;
  assign w_dok = ((r_state == S_DATA) & data_ok) | (w_aok & data_ok);
  // Arbitrate whenever the port is free, including the completing cycle, so
  // back-to-back requests chain without an IDLE bubble.
  assign w_arb = (r_state == S_IDLE) | w_dok;
  assign w_any = inst_req | data_req;

`ifdef SRAML_ARB_RR_EN
  logic r_rr_last;          // last granted side, 1 = data
  assign w_pick_data = (inst_req & data_req) ? ~r_rr_last : data_req;
`else
  assign w_pick_data = data_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef SRAML_ARB_RR_EN
      r_rr_last <= 1'b1;
`endif
    end else if (w_arb) begin
      if (w_any) begin
        r_state <= S_ADDR;
        r_req   <= 1'b1;
        r_owner <= w_pick_data;
        r_wr    <= w_pick_data ? data_wr    : inst_wr;
        r_size  <= w_pick_data ? data_size  : inst_size;
        r_addr  <= w_pick_data ? data_addr  : inst_addr;
        r_wdata <= w_pick_data ? data_wdata : inst_wdata;
`ifdef SRAML_ARB_RR_EN
        r_rr_last <= w_pick_data;
`endif
      end else begin
        r_state <= S_IDLE;
        r_req   <= 1'b0;
      end
    end else if (w_aok) begin
      r_state <= S_DATA;
      r_req   <= 1'b0;
    end
  end

  assign req   = r_req;
  assign wr    = r_wr;
  assign size  = r_size;
  assign addr  = r_addr;
  assign wdata = r_wdata;

  assign inst_addr_ok = w_aok & ~r_owner;
  assign data_addr_ok = w_aok &  r_owner;
  assign inst_data_ok = w_dok & ~r_owner;
  assign data_data_ok = w_dok &  r_owner;

  // Read data is broadcast; consumers qualify it with their data_ok.
  assign inst_rdata = rdata;
  assign data_rdata = rdata;

endmodule

// File: tb/tb_sraml_bus_arbiter.sv
module tb_sraml_bus_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_wr;
  logic [1:0]    inst_size;
  logic [DW-1:0] inst_addr, inst_wdata;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr;
  logic [1:0]    data_size;
  logic [DW-1:0] data_addr, data_wdata;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          req, wr;
  logic [1:0]    size;
  logic [DW-1:0] addr, wdata;
  logic          addr_ok, data_ok;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  sraml_bus_arbiter #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  // Expected address-phase contents, pushed when a request is driven and
  // popped when the owner's addr_ok fires.
  typedef struct {
    logic        side;   // 0 inst, 1 data
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } txn_t;

  // One row per clock: inputs applied just after the edge, outputs checked
  // at the following falling edge.
  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic [1:0]  sb;     // 1 inst, 2 data, 3 data then inst
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [31:0] e_wdata;
    logic [3:0]  e_ok;   // {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}
    logic        chk;    // compare latched outputs against reset values
  } vec_t;

  localparam logic [1:0] ISZ = 2'd2;
  localparam logic [1:0] DSZ = 2'd1;

  txn_t sbq[$];
  vec_t tv[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic r, logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] dd, logic ao, logic dko,
                              logic [31:0] rdv, logic [1:0] s, logic er, logic [31:0] ea,
                              logic ew, logic [31:0] ed, logic [3:0] eo, logic c);
    vec_t v;
    v.rst = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwr = dw; v.daddr = da;
    v.dwdata = dd; v.aok = ao; v.dok = dko; v.rd = rdv; v.sb = s; v.e_req = er;
    v.e_addr = ea; v.e_wr = ew; v.e_wdata = ed; v.e_ok = eo; v.chk = c;
    return v;
  endfunction

  function automatic txn_t mk_txn(logic sd, logic [31:0] a, logic w, logic [31:0] d, logic [1:0] sz);
    txn_t t;
    t.side = sd; t.addr = a; t.wr = w; t.wdata = d; t.size = sz;
    return t;
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin
    txn_t t;
    if (inst_addr_ok || data_addr_ok) begin
      n_tests++;
      if (inst_addr_ok && data_addr_ok) begin
        n_fail++;
        $display("FAIL sb_onehot: both addr_ok high");
      end else if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: addr_ok side=%0d addr=%h, nothing expected", data_addr_ok, addr);
      end else begin
        t = sbq.pop_front();
        if ({data_addr_ok, addr, wr, wdata, size} !== {t.side, t.addr, t.wr, t.wdata, t.size}) begin
          n_fail++;
          $display("FAIL sb_txn: got side=%0d addr=%h wr=%0d wdata=%h size=%0d want side=%0d addr=%h wr=%0d wdata=%h size=%0d",
                   data_addr_ok, addr, wr, wdata, size, t.side, t.addr, t.wr, t.wdata, t.size);
        end
      end
    end
  end

  task automatic apply(vec_t v);
    rst = v.rst; inst_req = v.ireq; inst_addr = v.iaddr;
    data_req = v.dreq; data_wr = v.dwr; data_addr = v.daddr; data_wdata = v.dwdata;
    addr_ok = v.aok; data_ok = v.dok; rdata = v.rd;
    if (v.sb == 2'd2 || v.sb == 2'd3) sbq.push_back(mk_txn(1'b1, v.daddr, v.dwr, v.dwdata, DSZ));
    if (v.sb == 2'd1 || v.sb == 2'd3) sbq.push_back(mk_txn(1'b0, v.iaddr, 1'b0, 32'h0, ISZ));
  endtask

  task automatic check(vec_t v, int i);
    logic [3:0] oks;
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_tests++;
    if (req !== v.e_req) begin
      n_fail++; $display("FAIL row%0d req: got %b want %b", i, req, v.e_req);
    end
    n_tests++;
    if (oks !== v.e_ok) begin
      n_fail++; $display("FAIL row%0d oks: got %b want %b", i, oks, v.e_ok);
    end
    n_tests++;
    if (inst_rdata !== v.rd || data_rdata !== v.rd) begin
      n_fail++; $display("FAIL row%0d rdata: got %h/%h want %h", i, inst_rdata, data_rdata, v.rd);
    end
    if (v.chk) begin
      n_tests++;
      if ({addr, wr, wdata, size} !== {v.e_addr, v.e_wr, v.e_wdata, 2'b00}) begin
        n_fail++;
        $display("FAIL row%0d reset_latch: got addr=%h wr=%b wdata=%h size=%0d want zeros", i, addr, wr, wdata, size);
      end
    end else if (v.e_req) begin
      n_tests++;
      if ({addr, wr, wdata} !== {v.e_addr, v.e_wr, v.e_wdata}) begin
        n_fail++;
        $display("FAIL row%0d latch: got addr=%h wr=%b wdata=%h want addr=%h wr=%b wdata=%h",
                 i, addr, wr, wdata, v.e_addr, v.e_wr, v.e_wdata);
      end
    end
  endtask

  initial begin
    logic       exp_data;
    logic [3:0] oks;

    rst = 1'b1; inst_req = 0; inst_wr = 0; inst_size = ISZ; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = DSZ; data_addr = 0; data_wdata = 0;
    addr_ok = 0; data_ok = 0; rdata = 0;

    //           rst ir iaddr         dr dw daddr         dwdata        ao dk rd            sb  er ea            ew ed            ok       chk
    // reset state, slave oks ignored
    tv.push_back(mk(1, 1, 32'hBFC00000, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0,        0, 0, 32'h0,        0, 32'h0,        4'b0000, 1));
    // single fetch: addr_ok after 2 ADDR cycles, data_ok 3 cycles later
    tv.push_back(mk(0, 1, 32'hBFC00000, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 0, 32'hBFC00000, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 1, 32'hBFC00000, 0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 0, 32'hBFC00000, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 1, 32'hBFC00000, 0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 0, 32'hBFC00000, 0, 0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 1, 32'hBFC00000, 0, 32'h0,        4'b1000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 1, 32'h3C080001, 0, 0, 32'h0,        0, 32'h0,        4'b0100, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    // simultaneous: data write wins, inst chained with no IDLE
    tv.push_back(mk(0, 1, 32'h00400000, 1, 1, 32'h80001000, 32'hDEADBEEF, 0, 0, 32'h0,        3, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 1, 32'h00400000, 0, 1, 32'h80001000, 32'hDEADBEEF, 1, 0, 32'h0,        0, 1, 32'h80001000, 1, 32'hDEADBEEF, 4'b0010, 0));
    tv.push_back(mk(0, 1, 32'h00400000, 0, 1, 32'h80001000, 32'hDEADBEEF, 0, 1, 32'h11111111, 0, 0, 32'h0,        0, 32'h0,        4'b0001, 0));
    // zero-latency slave on inst; next data request issues on the following cycle
    tv.push_back(mk(0, 0, 32'h00400000, 1, 0, 32'h80002000, 32'hCAFEF00D, 1, 1, 32'h22222222, 2, 1, 32'h00400000, 0, 32'h0,        4'b1100, 0));
    // data drops request during ADDR; latched request held until addr_ok
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h80002000, 32'hCAFEF00D, 0, 0, 32'h0,        0, 1, 32'h80002000, 0, 32'hCAFEF00D, 4'b0000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 1, 32'h12345678, 32'h0,        0, 0, 32'h0,        0, 1, 32'h80002000, 0, 32'hCAFEF00D, 4'b0000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 1, 32'h80002000, 0, 32'hCAFEF00D, 4'b0010, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 1, 32'h33333333, 0, 0, 32'h0,        0, 32'h0,        4'b0001, 0));
    // spurious handshakes in IDLE
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        0, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    // spurious addr_ok in DATA, then the real data_ok still completes
    tv.push_back(mk(0, 1, 32'h00001000, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 1, 32'h00001000, 0, 32'h0,        4'b1000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 1, 32'h44444444, 0, 0, 32'h0,        0, 32'h0,        4'b0100, 0));
    // reset in DATA, late data_ok dropped
    tv.push_back(mk(0, 1, 32'h00002000, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 1, 32'h00002000, 0, 32'h0,        4'b1000, 0));
    tv.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 1, 32'h55555555, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 1));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        4'b0000, 1));
    // reset in ADDR clears req and latches
    tv.push_back(mk(0, 1, 32'h00003000, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 1, 32'h00003000, 0, 32'h0,        4'b0000, 0));
    tv.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        4'b0000, 1));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i]);
      @(negedge clk);
      check(tv[i], i);
      @(posedge clk);
      #1;
    end

    // Four back-to-back ties with a zero-latency slave. rr_last is 1 after
    // the last reset, so round-robin starts with inst and alternates.
    inst_req = 1; inst_addr = 32'h00400100;
    data_req = 1; data_wr = 1; data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
    addr_ok = 1; data_ok = 1; rdata = 32'h66666666;
    for (int k = 0; k < 4; k++) begin
`ifdef SRAML_ARB_RR_EN
      exp_data = (k % 2) == 1;
`else
      exp_data = 1'b1;
`endif
      if (exp_data) sbq.push_back(mk_txn(1'b1, 32'h80001000, 1'b1, 32'hDEADBEEF, DSZ));
      else          sbq.push_back(mk_txn(1'b0, 32'h00400100, 1'b0, 32'h0, ISZ));
    end
    @(negedge clk);
    n_tests++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL tie_idle req: got %b want 0", req); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) begin inst_req = 0; data_req = 0; end
`ifdef SRAML_ARB_RR_EN
      exp_data = (k % 2) == 1;
`else
      exp_data = 1'b1;
`endif
      @(negedge clk);
      oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
      n_tests++;
      if (req !== 1'b1 || oks !== (exp_data ? 4'b0011 : 4'b1100)) begin
        n_fail++;
        $display("FAIL tie%0d: got req=%b oks=%b want req=1 oks=%b", k, req, oks, exp_data ? 4'b0011 : 4'b1100);
      end
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_tests++;
    if (req !== 1'b0 || oks !== 4'b0000) begin
      n_fail++; $display("FAIL tie_end: got req=%b oks=%b want req=0 oks=0000", req, oks);
    end
    addr_ok = 0; data_ok = 0;

    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d pending want 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
